// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin transaction scheduler that shares a single
// SPI master datapath between NUM_REQ requesters. Each grant performs one
// byte transfer and is followed by a chip-select guard gap.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   defined   -> read transfers that see no m_rx_valid within TIMEOUT XFER
//                cycles complete with err=1 and rx_data unchanged.
//   undefined -> a read transfer waits in XFER until m_rx_valid or reset.
module spi_xfer_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int GUARD_CYCLES = 2,
  parameter int WR_CYCLES    = 9,
  parameter int TIMEOUT      = 32
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_slave,
  input  logic [2*NUM_REQ-1:0] req_rw,
  input  logic [2*NUM_REQ-1:0] req_mode,
  input  logic [8*NUM_REQ-1:0] req_tx,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rx_data,
  output logic                 busy,
  output logic [1:0]           m_cs,
  output logic [1:0]           m_rw,
  output logic [1:0]           m_mode,
  output logic [7:0]           m_tx,
  input  logic [7:0]           m_rx,
  input  logic                 m_rx_valid
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  // One cycle counter serves both the write length and the read timeout.
  localparam int CNT_MAX = (WR_CYCLES > TIMEOUT) ? WR_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_DONE,
    S_GUARD
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   pick;
  logic               pick_vld;
  logic [1:0]         cmd_slave, cmd_rw, cmd_mode;
  logic [7:0]         cmd_tx;
  logic               cmd_inv;
  logic               err_flag;
  logic [CNT_W-1:0]   xfer_cnt;
  logic [3:0]         guard_cnt;
  logic               timeout_hit;
  logic               owned;

  // Per-requester command fields unpacked from the flat buses.
  logic [1:0] slave_a [NUM_REQ];
  logic [1:0] rw_a    [NUM_REQ];
  logic [1:0] mode_a  [NUM_REQ];
  logic [7:0] tx_a    [NUM_REQ];

  // Split the flat request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slave_a[i] = req_slave[2*i +: 2];
      rw_a[i]    = req_rw[2*i +: 2];
      mode_a[i]  = req_mode[2*i +: 2];
      tx_a[i]    = req_tx[8*i +: 8];
    end
  end

  // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a value before any branch, so
    // no path leaves it holding its old value (which would infer a latch).
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && req[PTR_W'(idx)]) begin
        pick_vld = 1'b1;
        pick     = PTR_W'(idx);
      end
    end
  end

  assign cmd_inv = (cmd_slave == 2'b00) || (cmd_rw == 2'b00);

`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout_hit = (xfer_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge sclk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = cmd_inv ? S_DONE : S_XFER;
      S_XFER: begin
        if (cmd_rw[1]) begin
          if (m_rx_valid || timeout_hit) state_nxt = S_DONE;
        end else if (xfer_cnt == CNT_W'(WR_CYCLES - 1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_GUARD;
      S_GUARD: if (guard_cnt == 4'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, counters, round-robin pointer and received byte.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      owner     <= '0;
      cmd_slave <= 2'b00;
      cmd_rw    <= 2'b00;
      cmd_mode  <= 2'b00;
      cmd_tx    <= 8'h00;
      err_flag  <= 1'b0;
      xfer_cnt  <= '0;
      guard_cnt <= 4'd0;
      rx_data   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          // Fields are frozen here; requester inputs are ignored afterwards.
          if (pick_vld) begin
            owner     <= pick;
            cmd_slave <= slave_a[pick];
            cmd_rw    <= rw_a[pick];
            cmd_mode  <= mode_a[pick];
            cmd_tx    <= tx_a[pick];
          end
        end
        S_LOAD: begin
          err_flag <= cmd_inv;
          xfer_cnt <= '0;
        end
        S_XFER: begin
          xfer_cnt <= xfer_cnt + 1'b1;
          if (cmd_rw[1]) begin
            if (m_rx_valid)       rx_data  <= m_rx;
            else if (timeout_hit) err_flag <= 1'b1;
          end
        end
        S_DONE: begin
          rr_ptr    <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          guard_cnt <= 4'(GUARD_CYCLES - 1);
        end
        S_GUARD: begin
          if (guard_cnt != 4'd0) guard_cnt <= guard_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign owned = (state == S_LOAD) || (state == S_XFER) || (state == S_DONE);

  // Grant/done decode for the owning requester.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (owned)            gnt[owner]  = 1'b1;
    if (state == S_DONE)  done[owner] = 1'b1;
  end

  assign err  = (state == S_DONE) && err_flag;
  assign busy = (state != S_IDLE);

  // Chip select only during XFER; invalid commands never reach XFER.
  assign m_cs   = (state == S_XFER) ? cmd_slave : 2'b00;
  assign m_rw   = owned ? cmd_rw : 2'b00;
  // Mode and tx byte change only on a new grant, while m_cs is still 0.
  assign m_mode = cmd_mode;
  assign m_tx   = cmd_tx;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed self-checking bench for spi_xfer_arbiter (default parameters).
module tb_spi_xfer_arbiter;

  localparam int NUM_REQ      = 3;
  localparam int GUARD_CYCLES = 2;
  localparam int WR_CYCLES    = 9;
  localparam int TIMEOUT      = 32;

  logic                 sclk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] req_slave, req_rw, req_mode;
  logic [8*NUM_REQ-1:0] req_tx;
  logic [NUM_REQ-1:0]   gnt, done;
  logic                 err, busy;
  logic [7:0]           rx_data, m_tx, m_rx;
  logic [1:0]           m_cs, m_rw, m_mode;
  logic                 m_rx_valid;

  int checks = 0;
  int errors = 0;

  spi_xfer_arbiter #(
    .NUM_REQ(NUM_REQ), .GUARD_CYCLES(GUARD_CYCLES),
    .WR_CYCLES(WR_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .sclk(sclk), .reset(reset), .req(req), .req_slave(req_slave),
    .req_rw(req_rw), .req_mode(req_mode), .req_tx(req_tx), .gnt(gnt),
    .done(done), .err(err), .rx_data(rx_data), .busy(busy), .m_cs(m_cs),
    .m_rw(m_rw), .m_mode(m_mode), .m_tx(m_tx), .m_rx(m_rx),
    .m_rx_valid(m_rx_valid)
  );

  always #5 sclk = ~sclk;

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic set_cmd(input int idx, input logic [1:0] slave,
                         input logic [1:0] rw, input logic [1:0] mode,
                         input logic [7:0] tx);
    req_slave[2*idx +: 2] = slave;
    req_rw[2*idx +: 2]    = rw;
    req_mode[2*idx +: 2]  = mode;
    req_tx[8*idx +: 8]    = tx;
  endtask

  // Bounded wait for the arbiter to return to IDLE.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({gnt, done, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b done=%b err=%b busy=%b, required all 0",
               gnt, done, err, busy);
    end
    checks++;
    if ({rx_data, m_cs, m_rw, m_mode, m_tx} !== 22'h0) begin
      errors++;
      $display("FAIL reset_data: rx=%h cs=%b rw=%b mode=%b tx=%h, required 0",
               rx_data, m_cs, m_rw, m_mode, m_tx);
    end
  endtask

  // req held at 111 with write commands: grants 0,1,2,0 and a guard gap.
  task automatic test_round_robin();
    logic [NUM_REQ-1:0] prev_gnt;
    logic [NUM_REQ-1:0] order [4];
    int ngrant = 0, guard_run = 0, idle_gap = 0, n = 0;
    set_cmd(0, 2'd1, 2'b01, 2'd0, 8'h11);
    set_cmd(1, 2'd2, 2'b01, 2'd1, 8'h22);
    set_cmd(2, 2'd3, 2'b01, 2'd2, 8'h33);
    req = 3'b111;
    prev_gnt = '0;
    while (ngrant < 4 && n < 100) begin
      step();
      n++;
      if (gnt == '0) begin
        idle_gap++;
        if (busy) guard_run++;
      end
      if (gnt != '0 && prev_gnt == '0) begin
        order[ngrant] = gnt;
        if (ngrant > 0) begin
          checks++;
          if (guard_run != GUARD_CYCLES) begin
            errors++;
            $display("FAIL rr_guard_len: %0d GUARD cycles, required %0d",
                     guard_run, GUARD_CYCLES);
          end
          checks++;
          if (idle_gap != GUARD_CYCLES + 1) begin
            errors++;
            $display("FAIL rr_turnaround: %0d cycles between done and load, required %0d",
                     idle_gap, GUARD_CYCLES + 1);
          end
        end
        ngrant++;
      end
      if (gnt != '0) begin
        guard_run = 0;
        idle_gap  = 0;
      end
      prev_gnt = gnt;
    end
    req = '0;
    checks++;
    if (ngrant != 4) begin
      errors++;
      $display("FAIL rr_count: %0d grants seen, required 4", ngrant);
    end else begin
      checks++;
      if ({order[0], order[1], order[2], order[3]} !== 12'b001_010_100_001) begin
        errors++;
        $display("FAIL rr_order: %b %b %b %b, required 001 010 100 001",
                 order[0], order[1], order[2], order[3]);
      end
    end
    wait_idle();
  endtask

  task automatic test_single_read();
    set_cmd(0, 2'd1, 2'b10, 2'd0, 8'hA5);
    req = 3'b001;
    step();  // LOAD
    req = '0;
    req_tx[7:0] = 8'hFF;  // must not affect the latched command
    checks++;
    if (gnt !== 3'b001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_load: gnt=%b busy=%b, required 001/1", gnt, busy);
    end
    for (int k = 0; k < 8; k++) begin
      step();  // XFER, waiting on the master
      checks++;
      if (m_cs !== 2'b01 || m_rw !== 2'b10 || m_tx !== 8'hA5 || done !== '0) begin
        errors++;
        $display("FAIL rd_xfer[%0d]: cs=%b rw=%b tx=%h done=%b, required 01/10/a5/000",
                 k, m_cs, m_rw, m_tx, done);
      end
    end
    m_rx = 8'h3C;
    m_rx_valid = 1'b1;
    step();  // DONE
    m_rx_valid = 1'b0;
    m_rx = 8'h00;
    checks++;
    if (done !== 3'b001 || err !== 1'b0 || rx_data !== 8'h3C || m_cs !== 2'b00) begin
      errors++;
      $display("FAIL rd_done: done=%b err=%b rx=%h cs=%b, required 001/0/3c/00",
               done, err, rx_data, m_cs);
    end
    step();  // GUARD
    checks++;
    if (done !== '0 || gnt !== '0 || m_rw !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_guard: done=%b gnt=%b rw=%b busy=%b, required 000/000/00/1",
               done, gnt, m_rw, busy);
    end
    wait_idle();
  endtask

  task automatic test_write();
    int first = -1;
    set_cmd(2, 2'd2, 2'b01, 2'd3, 8'hF0);
    req = 3'b100;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      step();
      if (k == 1) req = '0;
      if (k == 2) begin
        checks++;
        if (m_cs !== 2'b10 || m_mode !== 2'b11 || m_tx !== 8'hF0) begin
          errors++;
          $display("FAIL wr_xfer: cs=%b mode=%b tx=%h, required 10/11/f0",
                   m_cs, m_mode, m_tx);
        end
      end
      if (done != '0) begin
        first = k;
        checks++;
        if (done !== 3'b100 || err !== 1'b0) begin
          errors++;
          $display("FAIL wr_done: done=%b err=%b, required 100/0", done, err);
        end
      end
    end
    checks++;
    if (first != WR_CYCLES + 2) begin
      errors++;
      $display("FAIL wr_latency: done after %0d cycles, required %0d",
               first, WR_CYCLES + 2);
    end
    checks++;
    if (rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL wr_rx_hold: rx=%h, required 3c", rx_data);
    end
    wait_idle();
  endtask

  task automatic test_invalid();
    int first = -1;
    logic cs_seen = 1'b0;
    set_cmd(1, 2'd0, 2'b10, 2'd1, 8'h77);
    req = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) req = '0;
      if (m_cs != 2'b00) cs_seen = 1'b1;
      if (done != '0 && first < 0) begin
        first = k;
        checks++;
        if (done !== 3'b010 || err !== 1'b1) begin
          errors++;
          $display("FAIL inv_done: done=%b err=%b, required 010/1", done, err);
        end
      end
    end
    checks++;
    if (first != 2) begin
      errors++;
      $display("FAIL inv_latency: done after %0d cycles, required 2", first);
    end
    checks++;
    if (cs_seen !== 1'b0) begin
      errors++;
      $display("FAIL inv_cs: m_cs left 00, required 00 throughout");
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_xfer();
    set_cmd(1, 2'd3, 2'b11, 2'd1, 8'h5A);
    req = 3'b010;
    step();  // LOAD
    req = '0;
    step();  // XFER
    step();
    checks++;
    if (m_cs !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre: cs=%b, required 11", m_cs);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt, done, err, busy} !== '0 ||
        {rx_data, m_cs, m_rw, m_mode, m_tx} !== 22'h0) begin
      errors++;
      $display("FAIL rst_async: gnt=%b done=%b busy=%b rx=%h cs=%b rw=%b mode=%b tx=%h, required 0",
               gnt, done, busy, rx_data, m_cs, m_rw, m_mode, m_tx);
    end
    @(negedge sclk);
    reset = 1'b0;
    checks++;
    if (done !== '0) begin
      errors++;
      $display("FAIL rst_no_done: done=%b, required 000", done);
    end
    set_cmd(0, 2'd1, 2'b01, 2'd0, 8'h01);
    set_cmd(1, 2'd2, 2'b01, 2'd0, 8'h02);
    set_cmd(2, 2'd3, 2'b01, 2'd0, 8'h03);
    req = 3'b111;
    step();
    req = '0;
    checks++;
    if (gnt !== 3'b001) begin
      errors++;
      $display("FAIL rst_next_gnt: gnt=%b, required 001", gnt);
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    set_cmd(0, 2'd1, 2'b10, 2'd0, 8'hC3);
    req = 3'b001;
`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int first = -1;
      for (int k = 1; k <= TIMEOUT + 10 && first < 0; k++) begin
        step();
        if (k == 1) req = '0;
        if (done != '0) begin
          first = k;
          checks++;
          if (done !== 3'b001 || err !== 1'b1 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL to_done: done=%b err=%b rx=%h, required 001/1/00",
                     done, err, rx_data);
          end
        end
      end
      checks++;
      if (first != TIMEOUT + 2) begin
        errors++;
        $display("FAIL to_latency: done after %0d cycles, required %0d",
                 first, TIMEOUT + 2);
      end
      wait_idle();
    end
`else
    begin
      logic done_seen = 1'b0;
      logic idle_seen = 1'b0;
      for (int k = 1; k <= 60; k++) begin
        step();
        if (k == 1) req = '0;
        if (done != '0) done_seen = 1'b1;
        if (!busy) idle_seen = 1'b1;
      end
      checks++;
      if (done_seen !== 1'b0 || idle_seen !== 1'b0 || m_cs !== 2'b01) begin
        errors++;
        $display("FAIL to_wait: done_seen=%b idle_seen=%b cs=%b, required 0/0/01",
                 done_seen, idle_seen, m_cs);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
    end
`endif
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    req_slave  = '0;
    req_rw     = '0;
    req_mode   = '0;
    req_tx     = '0;
    m_rx       = 8'h00;
    m_rx_valid = 1'b0;
    @(negedge sclk);
    @(negedge sclk);
    test_reset();
    reset = 1'b0;
    step();
    test_round_robin();
    test_single_read();
    test_write();
    test_invalid();
    test_reset_mid_xfer();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
